beat_sequencer: RTL and testbench
=================================

Name:
beat_sequencer

Overview:
- Parametrised multi-song, multi-channel beat sequencer clocked by clk22 (beat clock).
- Replaces the free-running 0..1200 beat counter and single enable in the top level.
- Adds song select, play/pause/stop FSM, one-shot or loop mode, runtime tempo divider, per-channel mute and an end-of-song pulse.
- Drives the beat address into the external combinational score ROMs and returns registered per-channel tone values to the note generator.

Parameters:
BEAT_W, 12, width of beat address.
NUM_SONGS, 4, number of selectable songs.
SONG_SEL_W, 2, width of song_sel; 2**SONG_SEL_W >= NUM_SONGS.
SONG_LEN, {4{12'd1201}}, packed NUM_SONGS*BEAT_W lengths in beats; entry i at bits [i*BEAT_W +: BEAT_W].
CH, 2, number of tone channels.
TONE_W, 32, width of one tone value.
TONE_SIL, 32'd50000000, tone value meaning silence.

Ports:
clk22  in  1  beat clock
rst  in  1  reset
play  in  1  level; 1 = run, 0 = stop and rewind
pause  in  1  level; 1 = hold position while playing
loop_en  in  1  1 = wrap at song end, 0 = one-shot
song_sel  in  SONG_SEL_W  song request, sampled in IDLE only
tempo_div  in  4  beat advances every tempo_div+1 clk22 cycles
mute  in  CH  per-channel mute
tone_in  in  CH*TONE_W  score ROM output for (song_out, beat_addr); channel c at [c*TONE_W +: TONE_W]
beat_addr  out  BEAT_W  current beat
song_out  out  SONG_SEL_W  latched song
tone_out  out  CH*TONE_W  registered tones, same packing as tone_in
en_out  out  1  1 while state is PLAY
song_done  out  1  one-cycle pulse on last beat
state_out  out  2  00 IDLE, 01 PLAY, 10 PAUSE, 11 DONE

Behaviour:
- Reset: rst is asynchronous and active-high; clock is clk22.
- Reset values: state IDLE; beat_addr 0; song_out 0; tick_cnt 0; every tone_out channel TONE_SIL; en_out 0; song_done 0.
- len = SONG_LEN entry of song_out. A length of 0 is treated as 1. song_sel >= NUM_SONGS is clamped to NUM_SONGS-1.
- IDLE:
  - beat_addr = 0, tick_cnt = 0, song_out = song_sel each cycle.
  - play=1 -> PLAY. beat 0 is already presented to the ROM.
- PLAY:
  - play=0 -> IDLE. This has highest priority.
  - Otherwise pause=1 -> PAUSE. beat_addr and tick_cnt are held.
  - Otherwise, if tick_cnt >= tempo_div: tick_cnt <= 0 and the beat advances. Otherwise tick_cnt +1.
  - The >= compare covers a tempo_div lowered mid-count: the beat advances on the next cycle.
- Beat advance:
  - If beat_addr == len-1: song_done=1 for that one cycle. Then loop_en=1 -> beat_addr <= 0 and stay in PLAY; loop_en=0 -> DONE with beat_addr held at len-1.
  - Otherwise beat_addr +1.
  - loop_en is sampled only at the wrap point.
- PAUSE: play=0 -> IDLE; pause=0 -> PLAY. Position and tick_cnt resume unchanged.
- DONE: play=0 -> IDLE. Holding play=1 never restarts; play must drop for at least 1 cycle first.
- song_sel changes outside IDLE are ignored.
- tone_out, channel c, registered: tone_out <= (next state is PLAY and mute[c]==0) ? tone_in[c] : TONE_SIL.
  - Latency: the tone for beat_addr=N appears 1 clk22 after beat_addr becomes N.
  - mute takes effect on the next edge.
- en_out registered: it equals (state==PLAY) of the same cycle as tone_out.
- song_done is registered and pulses at most once per pass through the song.
- rst asserted mid-song: immediate return to reset values. No pulse is emitted.

Test Plan:
1. Reset, SONG_LEN[0]=4, tempo_div=0, loop_en=0, play=1 -> beat_addr 0,1,2,3; song_done high in the cycle beat_addr==3; then DONE with beat_addr 3; tone_out = TONE_SIL from the following cycle.
2. Same as 1 with loop_en=1 -> beat_addr 0,1,2,3,0,1; song_done pulses once per wrap; state stays 01.
3. tempo_div=2 -> each beat_addr value is held exactly 3 cycles. Drop tempo_div to 0 when tick_cnt=2 -> advance on the next cycle.
4. pause=1 at beat 5 for 10 cycles -> state 10, beat_addr stays 5, tone_out = TONE_SIL. Release -> the beat resumes at 5 with the same residual tick count.
5. song_sel=2 in IDLE, then play=1; change song_sel to 1 mid-song -> song_out stays 2. play=0 -> IDLE with beat_addr 0 and song_out 1 on the next cycle.
6. CH=2, tone_in={32'd191571,32'd95785}, mute=2'b10 -> tone_out ch0 = 95785, ch1 = TONE_SIL one cycle later. Assert rst mid-song -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/beat_sequencer.sv
// Multi-song, multi-channel beat sequencer: steps a beat address through the
// selected song at a programmable tempo and registers the per-channel tones.
module beat_sequencer #(
    parameter int                          BEAT_W     = 12,
    parameter int                          NUM_SONGS  = 4,
    parameter int                          SONG_SEL_W = 2,
    parameter logic [NUM_SONGS*BEAT_W-1:0] SONG_LEN   = {4{12'd1201}},
    parameter int                          CH         = 2,
    parameter int                          TONE_W     = 32,
    parameter logic [TONE_W-1:0]           TONE_SIL   = 32'd50000000
) (
    input  logic                   clk22,
    input  logic                   rst,
    input  logic                   play,
    input  logic                   pause,
    input  logic                   loop_en,
    input  logic [SONG_SEL_W-1:0]  song_sel,
    input  logic [3:0]             tempo_div,
    input  logic [CH-1:0]          mute,
    input  logic [CH*TONE_W-1:0]   tone_in,
    output logic [BEAT_W-1:0]      beat_addr,
    output logic [SONG_SEL_W-1:0]  song_out,
    output logic [CH*TONE_W-1:0]   tone_out,
    output logic                   en_out,
    output logic                   song_done,
    output logic [1:0]             state_out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PLAY  = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic [SONG_SEL_W-1:0] LAST_SONG = SONG_SEL_W'(NUM_SONGS - 1);
    localparam logic [CH*TONE_W-1:0]  SIL_ALL   = {CH{TONE_SIL}};

    state_t                  r_state;
    logic [BEAT_W-1:0]       r_beat;
    logic [3:0]              r_tick;
    logic [SONG_SEL_W-1:0]   r_song;
    logic [CH*TONE_W-1:0]    r_tone;
    logic                    r_en;
    logic                    r_done;

    logic [SONG_SEL_W-1:0]   w_song_sel;
    logic [BEAT_W-1:0]       w_len;
    logic [BEAT_W-1:0]       w_len_m1;
    logic                    w_last;
    logic                    w_tick_hit;
    logic [CH*TONE_W-1:0]    w_tone_play;

    // Out-of-range song requests fall back to the highest implemented song.
    always_comb begin
        w_song_sel = (song_sel > LAST_SONG) ? LAST_SONG : song_sel;
    end

    // Length of the latched song; a zero-length entry behaves as one beat.
    always_comb begin
        w_len = SONG_LEN[BEAT_W-1:0];
        for (int i = 0; i < NUM_SONGS; i++) begin
            w_len = (r_song == SONG_SEL_W'(i)) ? SONG_LEN[i*BEAT_W +: BEAT_W] : w_len;
        end
        w_len_m1 = (w_len == '0) ? '0 : (w_len - BEAT_W'(1));
    end

    // Wrap and tempo decisions; >= makes a lowered tempo_div advance at once.
    always_comb begin
        w_last     = (r_beat >= w_len_m1);
        w_tick_hit = (r_tick >= tempo_div);
    end

    // Tones as they would be registered while playing, with muting applied.
    always_comb begin
        w_tone_play = SIL_ALL;
        for (int c = 0; c < CH; c++) begin
            w_tone_play[c*TONE_W +: TONE_W] = mute[c] ? TONE_SIL : tone_in[c*TONE_W +: TONE_W];
        end
    end

    // Sequencer FSM; tone/enable registers follow the state being entered.
    always_ff @(posedge clk22 or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_beat  <= '0;
            r_tick  <= 4'd0;
            r_song  <= '0;
            r_tone  <= SIL_ALL;
            r_en    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_beat <= '0;
                    r_tick <= 4'd0;
                    r_song <= w_song_sel;
                    if (play) begin
                        r_state <= ST_PLAY;
                        r_en    <= 1'b1;
                        r_tone  <= w_tone_play;
                    end else begin
                        r_state <= ST_IDLE;
                        r_en    <= 1'b0;
                        r_tone  <= SIL_ALL;
                    end
                end
                ST_PLAY: begin
                    if (!play) begin
                        r_state <= ST_IDLE;
                        r_beat  <= '0;
                        r_tick  <= 4'd0;
                        r_en    <= 1'b0;
                        r_tone  <= SIL_ALL;
                    end else if (pause) begin
                        r_state <= ST_PAUSE;
                        r_en    <= 1'b0;
                        r_tone  <= SIL_ALL;
                    end else if (w_tick_hit) begin
                        r_tick <= 4'd0;
                        if (w_last) begin
                            r_done <= 1'b1;
                            if (loop_en) begin
                                r_beat <= '0;
                                r_en   <= 1'b1;
                                r_tone <= w_tone_play;
                            end else begin
                                r_state <= ST_DONE;
                                r_en    <= 1'b0;
                                r_tone  <= SIL_ALL;
                            end
                        end else begin
                            r_beat <= r_beat + BEAT_W'(1);
                            r_en   <= 1'b1;
                            r_tone <= w_tone_play;
                        end
                    end else begin
                        r_tick <= r_tick + 4'd1;
                        r_en   <= 1'b1;
                        r_tone <= w_tone_play;
                    end
                end
                ST_PAUSE: begin
                    if (!play) begin
                        r_state <= ST_IDLE;
                        r_beat  <= '0;
                        r_tick  <= 4'd0;
                        r_en    <= 1'b0;
                        r_tone  <= SIL_ALL;
                    end else if (!pause) begin
                        r_state <= ST_PLAY;
                        r_en    <= 1'b1;
                        r_tone  <= w_tone_play;
                    end else begin
                        r_state <= ST_PAUSE;
                        r_en    <= 1'b0;
                        r_tone  <= SIL_ALL;
                    end
                end
                ST_DONE: begin
                    // Only a drop of play rearms the song; holding play stays here.
                    if (!play) begin
                        r_state <= ST_IDLE;
                        r_beat  <= '0;
                        r_tick  <= 4'd0;
                    end else begin
                        r_state <= ST_DONE;
                    end
                    r_en   <= 1'b0;
                    r_tone <= SIL_ALL;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_beat  <= '0;
                    r_tick  <= 4'd0;
                    r_en    <= 1'b0;
                    r_tone  <= SIL_ALL;
                end
            endcase
        end
    end

    assign beat_addr = r_beat;
    assign song_out  = r_song;
    assign tone_out  = r_tone;
    assign en_out    = r_en;
    assign song_done = r_done;
    assign state_out = r_state;

endmodule

// File: tb/tb_beat_sequencer.sv
// Self-checking bench for beat_sequencer: directed scenarios plus random
// stimulus, all checked against a cycle-level model of the sequencing rules.
module tb_beat_sequencer;

    localparam int                   BW  = 12;
    localparam int                   NS  = 4;
    localparam int                   SW  = 2;
    localparam int                   CH  = 2;
    localparam int                   TW  = 32;
    localparam logic [31:0]          SIL = 32'd50000000;
    localparam logic [NS*BW-1:0]     LENP = {12'd0, 12'd6, 12'd9, 12'd4};
    localparam logic [81:0]          RESET_VEC = {12'd0, 2'd0, SIL, SIL, 1'b0, 1'b0, 2'b00};

    int lens [NS] = '{4, 9, 6, 0};

    logic               clk22 = 1'b0;
    logic               rst;
    logic               play, pause, loop_en;
    logic [SW-1:0]      song_sel;
    logic [3:0]         tempo_div;
    logic [CH-1:0]      mute;
    logic [CH*TW-1:0]   tone_in;
    logic [BW-1:0]      beat_addr;
    logic [SW-1:0]      song_out;
    logic [CH*TW-1:0]   tone_out;
    logic               en_out, song_done;
    logic [1:0]         state_out;

    logic               fixed_rom;
    logic [31:0]        salt;
    int                 n_cmp = 0;
    int                 n_bad = 0;

    // reference model state
    int                 m_state, m_beat, m_tick, m_song;
    logic [CH*TW-1:0]   m_tone;
    logic               m_en, m_done;
    logic [81:0]        exp_s;
    logic [81:0]        obs;

    beat_sequencer #(
        .BEAT_W(BW), .NUM_SONGS(NS), .SONG_SEL_W(SW), .SONG_LEN(LENP),
        .CH(CH), .TONE_W(TW), .TONE_SIL(SIL)
    ) dut (
        .clk22(clk22), .rst(rst), .play(play), .pause(pause), .loop_en(loop_en),
        .song_sel(song_sel), .tempo_div(tempo_div), .mute(mute), .tone_in(tone_in),
        .beat_addr(beat_addr), .song_out(song_out), .tone_out(tone_out),
        .en_out(en_out), .song_done(song_done), .state_out(state_out)
    );

    always #5 clk22 = ~clk22;

    function automatic logic [31:0] rom_val(input logic fx, input logic [31:0] sl,
                                            input int s, input int b, input int c);
        if (fx) return (c == 0) ? 32'd95785 : 32'd191571;
        return sl + 32'(s) * 32'd1000000 + 32'(b) * 32'd100 + 32'(c);
    endfunction

    // combinational score ROM seen by the DUT
    always_comb begin
        for (int c = 0; c < CH; c++)
            tone_in[c*TW +: TW] = rom_val(fixed_rom, salt, int'(song_out), int'(beat_addr), c);
    end

    assign obs = {beat_addr, song_out, tone_out, en_out, song_done, state_out};

    task automatic model_reset();
        m_state = 0; m_beat = 0; m_tick = 0; m_song = 0;
        m_tone = {CH{SIL}}; m_en = 1'b0; m_done = 1'b0;
        exp_s = {12'(m_beat), 2'(m_song), m_tone, m_en, m_done, 2'(m_state)};
    endtask

    // One beat-clock edge of the sequencing rules: 0 idle, 1 play, 2 pause, 3 done.
    task automatic model_step();
        int len, ns;
        logic [CH*TW-1:0] tn;
        len = lens[m_song];
        if (len == 0) len = 1;
        for (int c = 0; c < CH; c++) tn[c*TW +: TW] = rom_val(fixed_rom, salt, m_song, m_beat, c);
        m_done = 1'b0;
        ns = m_state;
        if (m_state == 0) begin
            m_beat = 0; m_tick = 0;
            m_song = (int'(song_sel) > NS - 1) ? NS - 1 : int'(song_sel);
            if (play) ns = 1;
        end else if (!play) begin
            ns = 0; m_beat = 0; m_tick = 0;
        end else if (m_state == 1) begin
            if (pause) ns = 2;
            else if (m_tick >= int'(tempo_div)) begin
                m_tick = 0;
                if (m_beat == len - 1) begin
                    m_done = 1'b1;
                    if (loop_en) m_beat = 0;
                    else ns = 3;
                end else m_beat = m_beat + 1;
            end else m_tick = m_tick + 1;
        end else if (m_state == 2) begin
            if (!pause) ns = 1;
        end
        m_state = ns;
        m_en = (ns == 1);
        for (int c = 0; c < CH; c++)
            m_tone[c*TW +: TW] = (ns == 1 && !mute[c]) ? tn[c*TW +: TW] : SIL;
        exp_s = {12'(m_beat), 2'(m_song), m_tone, m_en, m_done, 2'(m_state)};
    endtask

    task automatic step();
        @(posedge clk22);
        model_step();
        @(negedge clk22);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk22);
        @(negedge clk22);
        n_cmp++;
        if (obs !== RESET_VEC) begin n_bad++; $display("FAIL reset_values: got %h expected %h", obs, RESET_VEC); end
        rst = 1'b0;
        model_reset();
        step();
        n_cmp++;
        if (obs !== exp_s) begin n_bad++; $display("FAIL reset_idle: got %h expected %h", obs, exp_s); end
    endtask

    task automatic test_oneshot();
        song_sel = 2'd0; tempo_div = 4'd0; loop_en = 1'b0; play = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if (obs !== exp_s) begin n_bad++; $display("FAIL oneshot_vec: got %h expected %h", obs, exp_s); end
            n_cmp++;
            if ({beat_addr, state_out} !== {12'(i), 2'b01}) begin
                n_bad++; $display("FAIL oneshot_beat: got %0d/%b expected %0d/01", beat_addr, state_out, i);
            end
        end
        step();
        n_cmp++;
        if ({beat_addr, state_out, song_done, tone_out} !== {12'd3, 2'b11, 1'b1, SIL, SIL}) begin
            n_bad++; $display("FAIL oneshot_end: got %h expected beat 3 DONE pulse silence", {beat_addr, state_out, song_done, tone_out});
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (obs !== exp_s) begin n_bad++; $display("FAIL oneshot_hold: got %h expected %h", obs, exp_s); end
        end
        play = 1'b0;
        step();
        n_cmp++;
        if (obs !== exp_s) begin n_bad++; $display("FAIL oneshot_idle: got %h expected %h", obs, exp_s); end
    endtask

    task automatic test_loop();
        int dones = 0;
        song_sel = 2'd0; tempo_div = 4'd0; loop_en = 1'b1; play = 1'b1;
        for (int j = 0; j < 10; j++) begin
            step();
            if (song_done === 1'b1) dones++;
            n_cmp++;
            if (obs !== exp_s) begin n_bad++; $display("FAIL loop_vec: got %h expected %h", obs, exp_s); end
            n_cmp++;
            if ({beat_addr, state_out} !== {12'(j % 4), 2'b01}) begin
                n_bad++; $display("FAIL loop_beat: got %0d/%b expected %0d/01", beat_addr, state_out, j % 4);
            end
        end
        n_cmp++;
        if (dones !== 2) begin n_bad++; $display("FAIL loop_pulses: got %0d expected 2", dones); end
        play = 1'b0;
        step();
    endtask

    task automatic test_tempo();
        song_sel = 2'd1; tempo_div = 4'd2; loop_en = 1'b0; play = 1'b1;
        for (int k = 0; k < 11; k++) begin
            step();
            n_cmp++;
            if (obs !== exp_s) begin n_bad++; $display("FAIL tempo_vec: got %h expected %h", obs, exp_s); end
            if (k < 9) begin
                n_cmp++;
                if (beat_addr !== 12'(k / 3)) begin n_bad++; $display("FAIL tempo_hold: got %0d expected %0d", beat_addr, k / 3); end
            end
        end
        tempo_div = 4'd0;
        step();
        n_cmp++;
        if (beat_addr !== 12'd4) begin n_bad++; $display("FAIL tempo_lower: got %0d expected 4", beat_addr); end
        n_cmp++;
        if (obs !== exp_s) begin n_bad++; $display("FAIL tempo_lower_vec: got %h expected %h", obs, exp_s); end
        play = 1'b0;
        step();
    endtask

    task automatic test_pause();
        song_sel = 2'd1; tempo_div = 4'd1; loop_en = 1'b0; play = 1'b1;
        for (int k = 0; k < 40 && m_beat != 5; k++) step();
        n_cmp++;
        if (beat_addr !== 12'd5) begin n_bad++; $display("FAIL pause_reach: got %0d expected 5", beat_addr); end
        pause = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            n_cmp++;
            if ({beat_addr, state_out, en_out, tone_out} !== {12'd5, 2'b10, 1'b0, SIL, SIL}) begin
                n_bad++; $display("FAIL pause_hold: got %h expected beat 5 PAUSE silence", {beat_addr, state_out, en_out, tone_out});
            end
        end
        pause = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++;
            if ({beat_addr, state_out} !== {12'((k == 2) ? 6 : 5), 2'b01}) begin
                n_bad++; $display("FAIL pause_resume: got %0d/%b expected %0d/01", beat_addr, state_out, (k == 2) ? 6 : 5);
            end
            n_cmp++;
            if (obs !== exp_s) begin n_bad++; $display("FAIL pause_vec: got %h expected %h", obs, exp_s); end
        end
        play = 1'b0;
        step();
    endtask

    task automatic test_song_sel();
        play = 1'b0; song_sel = 2'd2; tempo_div = 4'd0; loop_en = 1'b0;
        step();
        play = 1'b1;
        step();
        song_sel = 2'd1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++;
            if (song_out !== 2'd2) begin n_bad++; $display("FAIL song_latched: got %0d expected 2", song_out); end
        end
        play = 1'b0;
        step();
        step();
        n_cmp++;
        if ({beat_addr, song_out, state_out} !== {12'd0, 2'd1, 2'b00}) begin
            n_bad++; $display("FAIL song_idle: got %h expected beat 0 song 1 IDLE", {beat_addr, song_out, state_out});
        end
        n_cmp++;
        if (obs !== exp_s) begin n_bad++; $display("FAIL song_vec: got %h expected %h", obs, exp_s); end
    endtask

    task automatic test_mute_reset();
        song_sel = 2'd0; tempo_div = 4'd0; loop_en = 1'b1; fixed_rom = 1'b1; mute = 2'b10; play = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++;
            if (tone_out !== {SIL, 32'd95785}) begin n_bad++; $display("FAIL mute_ch1: got %h expected %h", tone_out, {SIL, 32'd95785}); end
        end
        mute = 2'b01;
        step();
        n_cmp++;
        if (tone_out !== {32'd191571, SIL}) begin n_bad++; $display("FAIL mute_ch0: got %h expected %h", tone_out, {32'd191571, SIL}); end
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if (obs !== RESET_VEC) begin n_bad++; $display("FAIL async_reset: got %h expected %h", obs, RESET_VEC); end
        model_reset();
        @(negedge clk22);
        rst = 1'b0; fixed_rom = 1'b0; play = 1'b0; mute = 2'b00;
        step();
        n_cmp++;
        if (obs !== exp_s) begin n_bad++; $display("FAIL after_reset: got %h expected %h", obs, exp_s); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            play      = ($urandom_range(0, 31) != 0);
            pause     = ($urandom_range(0, 7) == 0);
            loop_en   = 1'($urandom_range(0, 1));
            tempo_div = 4'($urandom_range(0, 3));
            mute      = 2'($urandom_range(0, 3));
            song_sel  = 2'($urandom_range(0, 3));
            step();
            n_cmp++;
            if (obs !== exp_s) begin n_bad++; $display("FAIL random_vec: cycle %0d got %h expected %h", k, obs, exp_s); end
        end
    endtask

    initial begin
        rst = 1'b1; play = 1'b0; pause = 1'b0; loop_en = 1'b0;
        song_sel = '0; tempo_div = 4'd0; mute = '0;
        fixed_rom = 1'b0; salt = $urandom;
        model_reset();
        test_reset();
        test_oneshot();
        test_loop();
        test_tempo();
        test_pause();
        test_song_sel();
        test_mute_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
